// File: rtl/prefetch_pkg.sv
// Shared prefetch definitions: fault marker codes, fetch buffer sizing,
// alignment FSM state and the entry-length decode helper.
package prefetch_pkg;

    localparam logic [3:0] PREFETCH_GP_FAULT = 4'hF;
    localparam logic [3:0] PREFETCH_PF_FAULT = 4'hE;

    localparam int FETCH_BUF_BYTES = 12;
    localparam int FETCH_WIN_BYTES = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fa_state_e;

    // Bytes carried by a FIFO entry; markers and empty entries carry none.
    function automatic logic [3:0] entry_len(input logic [3:0] l);
        logic [3:0] n;
        if (l == PREFETCH_GP_FAULT || l == PREFETCH_PF_FAULT || l == 4'd0)
            n = 4'd0;
        else if (l > 4'd4)
            n = 4'd4;
        else
            n = l;
        return n;
    endfunction

endpackage

// File: rtl/fetch_align_shifter.sv
// Combinational consume/append step of the fetch byte buffer.
// Bytes above the new count are forced to zero.
module fetch_align_shifter
    import prefetch_pkg::*;
#(
    parameter int BUF_BYTES = FETCH_BUF_BYTES
) (
    input  logic [8*BUF_BYTES-1:0] sbuf_i,
    input  logic [3:0]             count_i,
    input  logic [3:0]             ce_i,
    input  logic [3:0]             new_len_i,
    input  logic [31:0]            new_i,
    output logic [8*BUF_BYTES-1:0] sbuf_o,
    output logic [3:0]             count_o
);

    logic [3:0]             rem;
    logic [8*BUF_BYTES-1:0] shifted;
    logic [8*BUF_BYTES-1:0] ext;

    always_comb begin
        rem     = count_i - ce_i;
        shifted = sbuf_i >> {ce_i, 3'b000};
        ext     = {{(8*BUF_BYTES-32){1'b0}}, new_i} << {rem, 3'b000};
        count_o = rem + new_len_i;
        sbuf_o  = '0;
        for (int i = 0; i < BUF_BYTES; i++) begin
            if (4'(i) < rem)
                sbuf_o[8*i +: 8] = shifted[8*i +: 8];
            else if (4'(i) < count_o)
                sbuf_o[8*i +: 8] = ext[8*i +: 8];
        end
    end

endmodule

// File: rtl/fetch_align.sv
// Prefetch FIFO to decoder byte aligner with in-order fault reporting.
// Optional stall counter enabled by FETCH_ALIGN_STATS_EN.
module fetch_align
    import prefetch_pkg::*;
#(
    parameter int BUF_BYTES = FETCH_BUF_BYTES,
    parameter int WIN_BYTES = FETCH_WIN_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pr_reset,
    input  logic                   prefetchfifo_accept_empty,
    input  logic [67:0]            prefetchfifo_accept_data,
    output logic                   prefetchfifo_accept_do,
    output logic [8*WIN_BYTES-1:0] dec_window,
    output logic [3:0]             dec_valid_bytes,
    output logic                   dec_fault_gp,
    output logic                   dec_fault_pf,
    input  logic                   dec_consume_do,
    input  logic [3:0]             dec_consume_len
`ifdef FETCH_ALIGN_STATS_EN
    ,
    output logic [31:0]            fetch_stall_count
`endif
);

    fa_state_e              state_q, state_d;
    logic [8*BUF_BYTES-1:0] sbuf_q, sbuf_d;
    logic [3:0]             count_q, count_d;
    logic                   gp_q, gp_d;
    logic                   pf_q, pf_d;
    logic [3:0]             ce;
    logic [3:0]             pop_len;
    logic [3:0]             marker;
    logic                   unused_hi;

    assign marker    = prefetchfifo_accept_data[67:64];
    assign unused_hi = ^prefetchfifo_accept_data[63:32];

    assign dec_valid_bytes = (count_q > 4'(WIN_BYTES)) ? 4'(WIN_BYTES) : count_q;
    assign dec_window      = sbuf_q[8*WIN_BYTES-1:0];
    assign dec_fault_gp    = gp_q;
    assign dec_fault_pf    = pf_q;

    always_comb begin
        ce = '0;
        if (dec_consume_do)
            ce = (dec_consume_len < dec_valid_bytes) ? dec_consume_len : dec_valid_bytes;
    end

    assign pop_len = prefetchfifo_accept_do ? entry_len(marker) : 4'd0;

    fetch_align_shifter #(
        .BUF_BYTES (BUF_BYTES)
    ) u_shifter (
        .sbuf_i    (sbuf_q),
        .count_i   (count_q),
        .ce_i      (ce),
        .new_len_i (pop_len),
        .new_i     (prefetchfifo_accept_data[31:0]),
        .sbuf_o    (sbuf_d),
        .count_o   (count_d)
    );

    always_ff @(posedge clk) begin
        if (rst || pr_reset)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        gp_d    = gp_q;
        pf_d    = pf_q;
        if (prefetchfifo_accept_do) begin
            if (marker == PREFETCH_GP_FAULT) begin
                gp_d    = 1'b1;
                state_d = FAULT;
            end else if (marker == PREFETCH_PF_FAULT) begin
                pf_d    = 1'b1;
                state_d = FAULT;
            end
        end
    end

    // Registered count only: no decoder-to-FIFO combinational path.
    always_comb begin
        prefetchfifo_accept_do = ~prefetchfifo_accept_empty && state_q == RUN &&
                                 count_q <= 4'(BUF_BYTES - 4) && ~pr_reset && ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst || pr_reset) begin
            sbuf_q  <= '0;
            count_q <= '0;
            gp_q    <= 1'b0;
            pf_q    <= 1'b0;
        end else begin
            sbuf_q  <= sbuf_d;
            count_q <= count_d;
            gp_q    <= gp_d;
            pf_q    <= pf_d;
        end
    end

`ifdef FETCH_ALIGN_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (state_q == RUN && dec_valid_bytes == 4'd0 && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign fetch_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fetch_align.sv
// Scoreboard bench for fetch_align: a byte-queue reference model predicts
// window, valid count, fault flags and pop decisions each cycle.
module tb_fetch_align;

    typedef struct {
        logic [63:0] win;
        logic [3:0]  vb;
        logic        gp;
        logic        pf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pr_reset;
    logic        prefetchfifo_accept_empty;
    logic [67:0] prefetchfifo_accept_data;
    logic        prefetchfifo_accept_do;
    logic [63:0] dec_window;
    logic [3:0]  dec_valid_bytes;
    logic        dec_fault_gp;
    logic        dec_fault_pf;
    logic        dec_consume_do;
    logic [3:0]  dec_consume_len;
`ifdef FETCH_ALIGN_STATS_EN
    logic [31:0] fetch_stall_count;
    int unsigned stat_exp;
`endif

    int tests = 0;
    int fails = 0;

    logic [67:0] fifo[$];
    logic [7:0]  ref_q[$];
    exp_t        sb[$];
    bit          m_gp, m_pf;

    always #5 clk = ~clk;

    fetch_align dut (
        .clk                       (clk),
        .rst                       (rst),
        .pr_reset                  (pr_reset),
        .prefetchfifo_accept_empty (prefetchfifo_accept_empty),
        .prefetchfifo_accept_data  (prefetchfifo_accept_data),
        .prefetchfifo_accept_do    (prefetchfifo_accept_do),
        .dec_window                (dec_window),
        .dec_valid_bytes           (dec_valid_bytes),
        .dec_fault_gp              (dec_fault_gp),
        .dec_fault_pf              (dec_fault_pf),
        .dec_consume_do            (dec_consume_do),
        .dec_consume_len           (dec_consume_len)
`ifdef FETCH_ALIGN_STATS_EN
        ,
        .fetch_stall_count         (fetch_stall_count)
`endif
    );

    function automatic logic [67:0] ent(input logic [3:0] l, input logic [31:0] d);
        return {l, 32'h0, d};
    endfunction

    // One clock: drive, check the pop decision, update model, then check outputs.
    task automatic drive_cycle(input bit cdo, input int clen, input bit fl);
        int   vb, ce, n;
        bit   acc_exp, popped;
        logic [67:0] e;
        exp_t x, got;
        dec_consume_do            = cdo;
        dec_consume_len           = 4'(clen);
        pr_reset                  = fl;
        prefetchfifo_accept_empty = (fifo.size() == 0);
        prefetchfifo_accept_data  = (fifo.size() == 0) ? 68'h0 : fifo[0];
        #3;
        vb = (ref_q.size() > 8) ? 8 : ref_q.size();
        ce = cdo ? ((clen < vb) ? clen : vb) : 0;
        acc_exp = (fifo.size() != 0) && !m_gp && !m_pf && ref_q.size() <= 8 && !fl;
        tests++;
        if (prefetchfifo_accept_do !== acc_exp) begin
            fails++;
            $display("FAIL accept_do: got %b expected %b", prefetchfifo_accept_do, acc_exp);
        end
        popped = prefetchfifo_accept_do;
        e = prefetchfifo_accept_data;
`ifdef FETCH_ALIGN_STATS_EN
        if (!m_gp && !m_pf && vb == 0) stat_exp++;
`endif
        if (fl) begin
            ref_q.delete();
            m_gp = 0;
            m_pf = 0;
        end else begin
            for (int i = 0; i < ce; i++) void'(ref_q.pop_front());
            if (acc_exp) begin
                if (e[67:64] == 4'hF) m_gp = 1;
                else if (e[67:64] == 4'hE) m_pf = 1;
                else begin
                    n = (e[67:64] > 4) ? 4 : int'(e[67:64]);
                    for (int i = 0; i < n; i++) ref_q.push_back(e[8*i +: 8]);
                end
            end
        end
        x.win = '0;
        for (int i = 0; i < 8 && i < ref_q.size(); i++) x.win[8*i +: 8] = ref_q[i];
        x.vb = 4'((ref_q.size() > 8) ? 8 : ref_q.size());
        x.gp = m_gp;
        x.pf = m_pf;
        sb.push_back(x);
        @(posedge clk);
        if (popped && fifo.size() != 0) void'(fifo.pop_front());
        #1;
        dec_consume_do = 0;
        pr_reset = 0;
        x = sb.pop_front();
        got = '{dec_window, dec_valid_bytes, dec_fault_gp, dec_fault_pf};
        tests++;
        if (got.win !== x.win) begin
            fails++;
            $display("FAIL window: got %h expected %h", got.win, x.win);
        end
        tests++;
        if (got.vb !== x.vb || got.gp !== x.gp || got.pf !== x.pf) begin
            fails++;
            $display("FAIL valid/flags: got %0d/%b/%b expected %0d/%b/%b",
                     got.vb, got.gp, got.pf, x.vb, x.gp, x.pf);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        fifo.delete();
        fifo.push_back(ent(4'd4, 32'h11111111));
        prefetchfifo_accept_empty = 0;
        prefetchfifo_accept_data  = fifo[0];
        #2;
        tests++;
        if (prefetchfifo_accept_do !== 1'b0) begin
            fails++;
            $display("FAIL reset_accept: got %b expected 0", prefetchfifo_accept_do);
        end
        @(posedge clk);
        #1;
        rst = 0;
        fifo.delete();
        ref_q.delete();
        m_gp = 0;
        m_pf = 0;
`ifdef FETCH_ALIGN_STATS_EN
        stat_exp = 0;
`endif
        prefetchfifo_accept_empty = 1;
        tests++;
        if (dec_window !== 64'h0 || dec_valid_bytes !== 4'd0 ||
            dec_fault_gp !== 1'b0 || dec_fault_pf !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got %h/%0d/%b/%b expected 0/0/0/0",
                     dec_window, dec_valid_bytes, dec_fault_gp, dec_fault_pf);
        end
    endtask

    task automatic test_fill();
        test_reset();
        fifo.push_back(ent(4'd4, 32'h03020100));
        fifo.push_back(ent(4'd4, 32'h07060504));
        fifo.push_back(ent(4'd4, 32'h0B0A0908));
        fifo.push_back(ent(4'd4, 32'h0F0E0D0C));
        drive_cycle(0, 0, 0);
        drive_cycle(0, 0, 0);
        tests++;
        if (dec_window !== 64'h0706050403020100 || dec_valid_bytes !== 4'd8) begin
            fails++;
            $display("FAIL fill_window: got %h/%0d expected 0706050403020100/8",
                     dec_window, dec_valid_bytes);
        end
        drive_cycle(0, 0, 0);
        drive_cycle(0, 0, 0);
        tests++;
        if (fifo.size() != 1) begin
            fails++;
            $display("FAIL fill_pops: got %0d left expected 1", fifo.size());
        end
    endtask

    task automatic test_consume();
        drive_cycle(1, 3, 0);
        tests++;
        if (dec_window !== 64'h0A09080706050403 || dec_valid_bytes !== 4'd8) begin
            fails++;
            $display("FAIL consume_window: got %h/%0d expected 0A09080706050403/8",
                     dec_window, dec_valid_bytes);
        end
        drive_cycle(0, 0, 0);
    endtask

    task automatic test_clamp();
        test_reset();
        fifo.push_back(ent(4'd2, 32'hDEADBBAA));
        drive_cycle(0, 0, 0);
        tests++;
        if (dec_window !== 64'hBBAA || dec_valid_bytes !== 4'd2) begin
            fails++;
            $display("FAIL clamp_window: got %h/%0d expected BBAA/2", dec_window, dec_valid_bytes);
        end
        drive_cycle(1, 5, 0);
        drive_cycle(0, 0, 0);
        tests++;
        if (dec_valid_bytes !== 4'd0) begin
            fails++;
            $display("FAIL clamp_underflow: got %0d expected 0", dec_valid_bytes);
        end
    endtask

    task automatic test_fault();
        test_reset();
        fifo.push_back(ent(4'd4, 32'h44332211));
        fifo.push_back(ent(4'hE, 32'h0));
        fifo.push_back(ent(4'd4, 32'h55555555));
        drive_cycle(0, 0, 0);
        drive_cycle(0, 0, 0);
        tests++;
        if (dec_fault_pf !== 1'b1 || dec_valid_bytes !== 4'd4 || dec_window !== 64'h44332211) begin
            fails++;
            $display("FAIL fault_pf: got %b/%0d/%h expected 1/4/44332211",
                     dec_fault_pf, dec_valid_bytes, dec_window);
        end
        drive_cycle(0, 0, 0);
        drive_cycle(1, 4, 0);
        tests++;
        if (dec_valid_bytes !== 4'd0 || dec_fault_pf !== 1'b1) begin
            fails++;
            $display("FAIL fault_drain: got %0d/%b expected 0/1", dec_valid_bytes, dec_fault_pf);
        end
    endtask

    task automatic test_flush();
        test_reset();
        fifo.push_back(ent(4'd4, 32'h04030201));
        fifo.push_back(ent(4'd2, 32'h00000605));
        fifo.push_back(ent(4'hF, 32'h0));
        drive_cycle(0, 0, 0);
        drive_cycle(0, 0, 0);
        drive_cycle(0, 0, 0);
        tests++;
        if (dec_fault_gp !== 1'b1 || dec_valid_bytes !== 4'd6) begin
            fails++;
            $display("FAIL flush_pre: got %b/%0d expected 1/6", dec_fault_gp, dec_valid_bytes);
        end
        drive_cycle(1, 3, 1);
        tests++;
        if (dec_fault_gp !== 1'b0 || dec_valid_bytes !== 4'd0 || dec_window !== 64'h0) begin
            fails++;
            $display("FAIL flush_clear: got %b/%0d/%h expected 0/0/0",
                     dec_fault_gp, dec_valid_bytes, dec_window);
        end
        fifo.push_back(ent(4'd4, 32'hDDCCBBAA));
        drive_cycle(0, 0, 0);
        tests++;
        if (dec_window !== 64'hDDCCBBAA || dec_valid_bytes !== 4'd4) begin
            fails++;
            $display("FAIL flush_resume: got %h/%0d expected DDCCBBAA/4", dec_window, dec_valid_bytes);
        end
    endtask

    task automatic test_back_to_back();
        test_reset();
        for (int c = 0; c < 300; c++) begin
            if (fifo.size() < 4 && $urandom_range(0, 3) != 0)
                fifo.push_back(ent(4'($urandom_range(0, 13)), $urandom));
            drive_cycle($urandom_range(0, 1) == 1, $urandom_range(1, 8), 0);
        end
    endtask

`ifdef FETCH_ALIGN_STATS_EN
    task automatic test_stats();
        test_reset();
        for (int c = 0; c < 5; c++) drive_cycle(0, 0, 0);
        tests++;
        if (fetch_stall_count !== 32'd5) begin
            fails++;
            $display("FAIL stats_count: got %0d expected 5", fetch_stall_count);
        end
        drive_cycle(0, 0, 1);
        tests++;
        if (fetch_stall_count !== 32'(stat_exp) || stat_exp != 6) begin
            fails++;
            $display("FAIL stats_flush: got %0d expected 6", fetch_stall_count);
        end
    endtask
`endif

    initial begin
        rst = 1;
        pr_reset = 0;
        dec_consume_do = 0;
        dec_consume_len = 0;
        prefetchfifo_accept_empty = 1;
        prefetchfifo_accept_data = '0;
        m_gp = 0;
        m_pf = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_consume();
        test_clamp();
        test_fault();
        test_flush();
        test_back_to_back();
`ifdef FETCH_ALIGN_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_align.md
# fetch_align

Byte-alignment stage directly downstream of the prefetch FIFO. It pops length-tagged 32-bit entries from the FIFO accept port and packs them into a 12-byte shift buffer. It presents an 8-byte little-endian instruction window to the decoder, which consumes a variable number of bytes per cycle. FIFO fault markers (GP/PF) are latched and reported in order behind all bytes that precede them.

## Interface
Parameters:
- `BUF_BYTES`, 12: shift-buffer capacity in bytes.
- `WIN_BYTES`, 8: decoder window width in bytes.

Ports:
- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `pr_reset`  in  1: pipeline flush (branch or exception). Synchronous; same effect as `rst` except on the stats counter.
- `prefetchfifo_accept_empty`  in  1: the FIFO (including its bypass path) has no entry.
- `prefetchfifo_accept_data`  in  68: [67:64] length/marker; [31:0] bytes, byte 0 at [7:0]; [63:32] ignored.
- `prefetchfifo_accept_do`  out  1: pop the FIFO this cycle.
- `dec_window`  out  64: buffer bytes 0..7; byte 0 at [7:0].
- `dec_valid_bytes`  out  4: min(count, 8).
- `dec_fault_gp`  out  1: GP marker latched; the stream ends after the valid bytes.
- `dec_fault_pf`  out  1: PF marker latched; the stream ends after the valid bytes.
- `dec_consume_do`  in  1: the decoder consumes bytes this cycle.
- `dec_consume_len`  in  4: number of bytes consumed (1..8).

## Operation
- State is a 4-bit `count` (0..12), a 96-bit byte buffer, and a 2-state FSM: RUN and FAULT.
- Pop rule:
  - `prefetchfifo_accept_do = ~prefetchfifo_accept_empty & state==RUN & count<=8 & ~pr_reset & ~rst`.
  - The rule uses the registered `count` only, so there is no combinational path from the decoder to the FIFO.
  - A pop always fits, even with zero consumption.
- Effective consume: `ce = dec_consume_do ? min(dec_consume_len, dec_valid_bytes) : 0`. Over-consumption is clamped and never underflows.
- Popped entry, by length field L:
  - L=1..4: append L bytes.
  - L=5..13: treat as 4.
  - L=0: discard; no bytes appended.
  - L=4'hF: set GP, go to FAULT, append nothing.
  - L=4'hE: set PF, go to FAULT, append nothing.
- Update in one cycle:
  - `buf' = (buf >> 8*ce) | (new_bytes << 8*(count-ce))`.
  - `count' = count - ce + Lbytes`.
  - Bytes above `count'` are don't-care internally but are driven as zero on `dec_window`.
- FAULT state:
  - No further pops.
  - Buffered bytes remain consumable.
  - The fault flags stay asserted until `pr_reset` or `rst`.
  - The decoder raises the fault only when it needs bytes beyond `dec_valid_bytes`.
- Reset and flush (`rst` or `pr_reset`):
  - count=0, buffer=0, state=RUN, flags=0.
  - `accept_do`=0 that cycle.
  - Any concurrent consume is ignored.

## Timing
- Reset values:
  - `prefetchfifo_accept_do`=0, `dec_window`=0, `dec_valid_bytes`=0, `dec_fault_gp`=0, `dec_fault_pf`=0.
  - Stats counter = 0.
- Pop in cycle N → bytes visible on `dec_window` in N+1.
- With the FIFO bypass, a prefetch write in cycle N reaches the decoder in N+1.
- Consume in cycle N → the window shifts in N+1. Consume and pop in the same cycle are both applied.
- Fault marker popped in N → flag high in N+1; `accept_do` low from N+1.
- `pr_reset` in N → empty window and RUN state in N+1; popping may resume in N+1.

## Configuration
- `FETCH_ALIGN_STATS_EN`: when defined, adds output `fetch_stall_count` (32 bits).
  - Increments each cycle with state==RUN and `dec_valid_bytes`==0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by `rst`, not by `pr_reset`.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- The shared package `prefetch_pkg` holds:
  - `PREFETCH_GP_FAULT`=4'hF and `PREFETCH_PF_FAULT`=4'hE (shared with the prefetch FIFO writer).
  - `FETCH_BUF_BYTES` and `FETCH_WIN_BYTES`.
  - The FSM state enum {RUN, FAULT}.
- Sub-module `fetch_align_shifter`: purely combinational. Inputs are the buffer, `ce`, `count` and new bytes; outputs are the next buffer and next count. The FSM, pop logic and registers stay in `fetch_align`.

## Test plan
- Three 4-byte entries 0x03020100, 0x07060504, 0x0B0A0908 with no consume:
  - Window 0x0706050403020100, valid=8.
  - Third entry popped (count==8 still allowed), count=12.
  - `accept_do` stays 0 while count=12.
- From count=12, consume 3:
  - Next window 0x0A09080706050403, count=9.
  - No pop the following cycle (count>8).
- Entry L=2 data 0xXXXXBBAA at count=0:
  - Window 0xBBAA, valid=2.
  - Consume_len=5 is clamped to 2; count=0, no underflow.
- Entries 0x44332211 (L=4), then marker 4'hE:
  - `dec_fault_pf`=1 with valid=4.
  - `accept_do`=0 despite a non-empty FIFO.
  - Consume 4 → valid=0, PF still 1.
- `pr_reset` while count=6 and FAULT with concurrent consume:
  - Next cycle: count=0, flags 0, state RUN.
  - The next 4-byte entry appears cleanly at byte 0.
- STATS build: 5 cycles with an empty FIFO after `rst` → `fetch_stall_count`=5. A `pr_reset` does not clear it.
